// File: rtl/as_pack.sv
// as_pack: shared types and constants for the load/store unit
package as_pack;
  localparam int be_width = 8;
  localparam int lsu_data_width = 64;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_t;
  function automatic logic [be_width-1:0] size_mask(lsu_size_t s);
    return s == SZ_D ? 8'hFF : s == SZ_W ? 8'h0F : s == SZ_H ? 8'h03 : 8'h01;
  endfunction
endpackage

// File: rtl/as_lsu_align.sv
// as_lsu_align: stateless lane steering, legality check and load extension
module as_lsu_align
  import as_pack::*;
(
  input  logic                      rd_i,
  input  logic                      wr_i,
  input  logic [2:0]                func3_i,
  input  logic [2:0]                off_i,
  input  logic [lsu_data_width-1:0] wdata_i,
  input  logic [lsu_data_width-1:0] brdata_i,
  output logic                      err_o,
  output logic [be_width-1:0]       be_o,
  output logic [lsu_data_width-1:0] bwdata_o,
  output logic [lsu_data_width-1:0] rdata_o
);
  lsu_size_t size;
  logic mis, sx;
  logic [lsu_data_width-1:0] sh;
  // decode size, flag illegal/misaligned, shift lanes and extend load data
  always_comb begin
    size = lsu_size_t'(func3_i[1:0]);
    mis = size == SZ_H ? off_i[0] : size == SZ_W ? |off_i[1:0] : size == SZ_D ? |off_i : 1'b0;
    err_o = (rd_i & wr_i) | (rd_i & &func3_i) | (wr_i & func3_i[2]) | ((rd_i | wr_i) & mis);
    be_o = size_mask(size) << off_i;
    bwdata_o = wdata_i << {off_i, 3'b000};
    sh = brdata_i >> {off_i, 3'b000};
    sx = ~func3_i[2];
    rdata_o = size == SZ_B ? {{56{sh[7] & sx}}, sh[7:0]} :
              size == SZ_H ? {{48{sh[15] & sx}}, sh[15:0]} :
              size == SZ_W ? {{32{sh[31] & sx}}, sh[31:0]} : sh;
  end
endmodule

// File: rtl/as_lsu.sv
// as_lsu: load/store unit driving a request/grant/response data-memory bus
module as_lsu
  import as_pack::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      dMemRd_i,
  input  logic                      dMemWr_i,
  input  logic [2:0]                func3_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [lsu_data_width-1:0] wdata_i,
  output logic [lsu_data_width-1:0] rdata_o,
  output logic                      stall_o,
  output logic                      err_o,
  output logic                      req_o,
  output logic                      we_o,
  output logic [ADDR_W-1:0]         baddr_o,
  output logic [be_width-1:0]       be_o,
  output logic [lsu_data_width-1:0] bwdata_o,
  input  logic                      gnt_i,
  input  logic                      rvalid_i,
  input  logic [lsu_data_width-1:0] brdata_i
);
  lsu_state_t state, next;
  logic req_v, err_c;
  logic [be_width-1:0] be_c;
  logic [lsu_data_width-1:0] bwdata_c, rext;
  assign req_v = dMemRd_i | dMemWr_i;
  as_lsu_align u_align (
    .rd_i     (dMemRd_i),
    .wr_i     (dMemWr_i),
    .func3_i  (func3_i),
    .off_i    (addr_i[2:0]),
    .wdata_i  (wdata_i),
    .brdata_i (brdata_i),
    .err_o    (err_c),
    .be_o     (be_c),
    .bwdata_o (bwdata_c),
    .rdata_o  (rext)
  );
  // state register; reset abandons any outstanding transaction
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= next;
  // next state, bus request and core stall
  always_comb begin
    next = state == IDLE ? (req_v ? (err_c ? DONE : REQ) : IDLE) :
           state == REQ  ? (gnt_i ? (we_o ? DONE : WAIT) : REQ) :
           state == WAIT ? (rvalid_i ? DONE : WAIT) : IDLE;
    req_o = state == REQ;
    stall_o = state == REQ || state == WAIT || (state == IDLE && req_v);
  end
  // capture bus fields on acceptance, error pulse for DONE, load result on response
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      we_o <= 1'b0;
      baddr_o <= '0;
      be_o <= '0;
      bwdata_o <= '0;
      rdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      err_o <= state == IDLE && req_v && err_c;
      if (state == IDLE && req_v && err_c) rdata_o <= '0;
      if (state == IDLE && req_v && !err_c) begin
        we_o <= dMemWr_i;
        baddr_o <= {addr_i[ADDR_W-1:3], 3'b000};
        be_o <= be_c;
        bwdata_o <= bwdata_c;
      end
      if (state == WAIT && rvalid_i) rdata_o <= rext;
    end
endmodule

// File: tb/tb_as_lsu.sv
// tb_as_lsu: randomized scoreboard bench for the load/store unit
module tb_as_lsu;
  logic clk = 1'b0, rst_i = 1'b1;
  logic dMemRd_i = 1'b0, dMemWr_i = 1'b0;
  logic [2:0] func3_i = '0;
  logic [63:0] addr_i = '0, wdata_i = '0, rdata_o, baddr_o, bwdata_o, brdata_i;
  logic stall_o, err_o, req_o, we_o, gnt_i, rvalid_i;
  logic [7:0] be_o;

  as_lsu #(.ADDR_W(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .dMemRd_i(dMemRd_i), .dMemWr_i(dMemWr_i),
    .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .stall_o(stall_o), .err_o(err_o), .req_o(req_o), .we_o(we_o),
    .baddr_o(baddr_o), .be_o(be_o), .bwdata_o(bwdata_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .brdata_i(brdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [63:0] baddr; logic [63:0] bwdata; logic [7:0] be;} bus_t;
  typedef struct {logic err; logic [63:0] rdata;} done_t;
  bus_t bus_q[$];
  done_t done_q[$];
  done_t dm;
  int n_cmp = 0, n_bad = 0;
  bit mon_en = 0, manual = 0;
  int g_dly = 0, r_dly = 0;
  logic [63:0] mem_data = '0, ref_rdata = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: bus fields while requesting, result and error in each completion cycle
  always @(negedge clk) begin
    if (mon_en && !rst_i) begin
      if (req_o) begin
        if (bus_q.size() == 0) check("bus_unexpected_req", 1, 0);
        else begin
          check("we", we_o, bus_q[0].we);
          check("baddr", baddr_o, bus_q[0].baddr);
          check("be", be_o, bus_q[0].be);
          check("bwdata", bwdata_o, bus_q[0].bwdata);
          if (gnt_i) void'(bus_q.pop_front());
        end
      end
      if ((dMemRd_i || dMemWr_i) && !stall_o) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          dm = done_q.pop_front();
          check("err_done", err_o, dm.err);
          check("rdata_done", rdata_o, dm.rdata);
        end
      end else check("err_not_done", err_o, 0);
    end
  end

  // memory responder: grant after g_dly cycles, read data r_dly cycles after the grant cycle
  initial begin
    gnt_i = 0; rvalid_i = 0; brdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!manual && req_o) begin
        repeat (g_dly) begin @(posedge clk); #1; end
        gnt_i = 1;
        @(posedge clk); #1;
        gnt_i = 0;
        if (!we_o) begin
          repeat (r_dly) begin @(posedge clk); #1; end
          rvalid_i = 1; brdata_i = mem_data;
          @(posedge clk); #1;
          rvalid_i = 0; brdata_i = {$urandom, $urandom};
        end
      end
    end
  end

  // issue one access, push expectations from the reference model, wait for completion
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] bd, input int gd, input int rdd);
    int n, off, st, cyc, exp_st, k;
    bit ill;
    logic [63:0] v;
    bus_t b;
    done_t d;
    n = 1 << f3[1:0];
    off = int'(a[2:0]);
    ill = (rd && wr) || (rd && f3 == 3'b111) || (wr && f3[2]) || (a % n != 0);
    if (ill) begin
      ref_rdata = '0;
      exp_st = 1;
    end else begin
      b.we = wr;
      b.baddr = a & ~64'h7;
      b.bwdata = wd << (8 * off);
      b.be = '0;
      for (int i = 0; i < n; i++) b.be[off+i] = 1'b1;
      bus_q.push_back(b);
      if (rd) begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = bd[8*(off+i) +: 8];
        k = 64 - 8 * n;
        if (!f3[2]) v = $signed(v << k) >>> k;
        ref_rdata = v;
        exp_st = 3 + gd + rdd;
      end else exp_st = 2 + gd;
    end
    d.err = ill;
    d.rdata = ref_rdata;
    done_q.push_back(d);
    g_dly = gd; r_dly = rdd; mem_data = bd;
    dMemRd_i = rd; dMemWr_i = wr; func3_i = f3; addr_i = a; wdata_i = wd;
    st = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (stall_o) st++;
    end while (stall_o && cyc < 40);
    check("stall_cycles", st, exp_st);
    @(posedge clk); #1;
    dMemRd_i = 0; dMemWr_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, wr;
    logic [2:0] f3;
    logic [63:0] a;
    repeat (2) @(negedge clk);
    check("rst_req", req_o, 0);
    check("rst_we", we_o, 0);
    check("rst_baddr", baddr_o, 0);
    check("rst_be", be_o, 0);
    check("rst_bwdata", bwdata_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_err", err_o, 0);
    @(posedge clk); #1;
    rst_i = 0;
    mon_en = 1;
    repeat (3) begin
      @(negedge clk);
      check("idle_stall", stall_o, 0);
      check("idle_req", req_o, 0);
    end
    @(posedge clk); #1;
    access(1, 0, 3'b000, 64'h1005, 64'h0, 64'h0000_80FF_0000_0000, 0, 0);
    check("lb_rdata", rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    access(1, 0, 3'b110, 64'h2004, 64'h0, 64'h8765_4321_DEAD_BEEF, 1, 1);
    check("lwu_rdata", rdata_o, 64'h0000_0000_8765_4321);
    access(0, 1, 3'b001, 64'h3006, 64'h1234_5678_9ABC_ABCD, 64'h0, 3, 0);
    check("sh_keeps_rdata", rdata_o, 64'h0000_0000_8765_4321);
    access(1, 0, 3'b011, 64'h4004, 64'h0, 64'h0, 0, 0);
    check("ld_mis_rdata", rdata_o, 0);
    access(1, 1, 3'b011, 64'h4000, 64'h0, 64'h0, 0, 0);
    for (int t = 0; t < 80; t++) begin
      rd = 1'($urandom_range(0, 1));
      wr = !rd;
      if ($urandom_range(0, 15) == 0) begin rd = 1; wr = 1; end
      f3 = 3'($urandom_range(0, 7));
      if (wr && !rd && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) a[2:0] = a[2:0] & 3'(~((1 << f3[1:0]) - 1));
      access(rd, wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    mon_en = 0; manual = 1;
    dMemRd_i = 1; dMemWr_i = 0; func3_i = 3'b011; addr_i = 64'h5000;
    @(posedge clk); #1;
    check("rw_req_up", req_o, 1);
    gnt_i = 1;
    @(posedge clk); #1;
    gnt_i = 0;
    check("rw_wait_stall", stall_o, 1);
    #2;
    rst_i = 1; dMemRd_i = 0;
    #1;
    check("rw_req_async", req_o, 0);
    check("rw_stall", stall_o, 0);
    check("rw_rdata", rdata_o, 0);
    @(posedge clk); #1;
    rst_i = 0; rvalid_i = 1; brdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    rvalid_i = 0;
    repeat (3) begin
      @(negedge clk);
      check("late_rdata", rdata_o, 0);
      check("late_err", err_o, 0);
      check("late_stall", stall_o, 0);
      check("late_req", req_o, 0);
    end
    bus_q.delete(); done_q.delete();
    ref_rdata = '0;
    @(posedge clk); #1;
    manual = 0; mon_en = 1;
    access(1, 0, 3'b100, 64'h6003, 64'h0, 64'h1122_3344_5566_7788, 0, 0);
    check("recover_lbu", rdata_o, 64'h55);
    check("bus_q_empty", bus_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
